iter_mult_unit: RTL and testbench
=================================

Name: iter_mult_unit

Overview:
Parametrised multi-cycle shift-add multiplier for the next-generation MIPS core: the multi-cycle successor to the current single-cycle datapath, which has no multiply support. It accepts one operand pair through a valid/ready handshake and computes one partial product per cycle. It returns a 2*WIDTH-bit product as HI/LO halves for MULT/MULTU, with a signed/unsigned mode select. It sits beside the ALU in the EX stage, and the control FSM stalls the PC while the unit is busy.

Parameters:
WIDTH, 32, operand width in bits; legal values 8..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset; clears all state immediately
mult_valid  input  1  request strobe; sampled only while mult_ready=1
mult_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU); sampled with mult_valid
mult_op1  input  WIDTH  multiplicand (rs)
mult_op2  input  WIDTH  multiplier (rt)
mult_ready  output  1  unit idle, can accept a request
mult_done  output  1  one-cycle pulse: product_hi/product_lo valid
product_hi  output  WIDTH  upper half of product (HI)
product_lo  output  WIDTH  lower half of product (LO)

Behaviour:
- Reset (async, active-high):
  - state=IDLE, mult_ready=1, mult_done=0, product_hi=0, product_lo=0.
  - Counter, internal accumulator and operand registers are cleared.
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE:
  - mult_ready=1.
  - On a clock edge with mult_valid=1, latch |op1| and |op2| (magnitudes only when mult_signed=1 and the operand MSB is 1; otherwise raw).
  - Latch neg = mult_signed & (op1[W-1] ^ op2[W-1]).
  - Clear the 2W-bit accumulator, set counter=WIDTH, go to CALC.
- CALC:
  - mult_ready=0.
  - Each cycle: if multiplier LSB is 1, accumulator += multiplicand shifted left by the iteration index, computed at 2W-bit width with no overflow. Then shift the multiplier right by 1 and decrement the counter.
  - After the iteration that takes the counter to 0, go to SIGN.
- SIGN:
  - If neg, accumulator = two's complement of the accumulator (2W bits). Go to DONE.
- DONE:
  - product_hi/lo = accumulator[2W-1:W]/[W-1:0]; mult_done=1 for exactly this cycle. Next state IDLE.
- Latency: the accept edge is edge 0; mult_done is high in the cycle after edge WIDTH+2, i.e. 34 cycles for WIDTH=32. Throughput is one result per WIDTH+3 cycles.
- product_hi/lo hold their last value until the next DONE; they do not change while CALC runs.
- mult_valid while mult_ready=0 is ignored and never queued. The requester must hold its request until it sees mult_ready=1.
- Back-to-back: mult_ready rises in the cycle after DONE. A request accepted then starts a fresh operation and the old result stays on the outputs until overwritten.
- Boundary values:
  - Magnitude of the most-negative value (-2^(W-1)) is 2^(W-1), which fits unsigned in W bits. The result must be exact, e.g. (-2^31)*(-2^31)=2^62.
  - Zero operand gives product 0 with no sign flip, since -0 = 0.
- Reset mid-operation: abort at once, return to IDLE with reset values. No mult_done pulse is generated for the aborted operation.

Optional Feature:
MULT_EARLY_TERM_EN.
- Defined: CALC also exits to SIGN when the remaining shifted multiplier is 0 after the current iteration. Minimum one CALC cycle.
  - Latency becomes (index of highest set bit of |op2|)+1 CALC cycles + 2.
  - op2=0 or op2=1 gives mult_done 3 edges after accept.
  - Results are identical to the non-early-termination build.
- Not defined: fixed WIDTH CALC cycles as specified above; the counter alone ends CALC.

Test Plan:
1. Reset held, then released → mult_ready=1, mult_done=0, product_hi=product_lo=0; asserting reset during CALC returns mult_ready=1 the same cycle and no mult_done pulse follows.
2. Unsigned 0xFFFFFFFF * 0xFFFFFFFF (WIDTH=32) → hi=0xFFFFFFFE, lo=0x00000001; mult_done exactly 34 cycles after accept.
3. Signed -1 * 31 → hi=0xFFFFFFFF, lo=0xFFFFFFE1; signed 18 * 31 → hi=0, lo=0x0000022E.
4. Signed 0x80000000 * 0x80000000 → hi=0x40000000, lo=0; same operands unsigned → hi=0x40000000, lo=0.
5. mult_valid held high throughout with new operands every cycle → only the first pair is accepted; the next accept occurs the cycle after mult_done; outputs are stable during CALC.
6. With MULT_EARLY_TERM_EN: 5 * 1 → product 5, done 3 edges after accept; 5 * 0x00010000 → done 19 edges after accept; random signed/unsigned pairs match a golden model in both builds.

Source files
------------

// File: rtl/iter_mult_unit.sv
// iter_mult_unit: multi-cycle shift-add multiplier for MULT/MULTU.
// One partial product per cycle on operand magnitudes, with the sign fixed up in one extra
// cycle. Returns a 2*WIDTH-bit product as HI/LO with a one-cycle mult_done pulse.
// Optional build macro MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier
// bits are all zero (results unchanged, latency data-dependent).
module iter_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_valid,
  input  logic             mult_signed,
  input  logic [WIDTH-1:0] mult_op1,
  input  logic [WIDTH-1:0] mult_op2,
  output logic             mult_ready,
  output logic             mult_done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  // Iteration counter width is derived from WIDTH and never overridden.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StSign = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("iter_mult_unit: WIDTH must be within 8..64");
  end

  // State
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_mcand;   // |op1| pre-shifted by the current iteration index
  logic [WIDTH-1:0] r_mplier;  // |op2|, consumed LSB first
  logic [PW-1:0]    r_acc;
  logic             r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Next-state values
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [PW-1:0]    w_mcand_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic [PW-1:0]    w_acc_next;
  logic             w_neg_next;
  logic             w_done_next;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  // Datapath helpers
  logic [WIDTH-1:0] w_op1_mag;
  logic [WIDTH-1:0] w_op2_mag;
  logic             w_neg_in;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_sum;
  logic [WIDTH-1:0] w_mplier_shr;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_calc_last;

  // Operand magnitudes; -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
  always_comb begin
    w_op1_mag = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
    w_op2_mag = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
    w_neg_in  = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
  end

  // One shift-add step: the 2W-bit accumulator cannot overflow with W-bit magnitudes.
  always_comb begin
    w_addend     = r_mplier[0] ? r_mcand : '0;
    w_acc_sum    = r_acc + w_addend;
    w_mplier_shr = r_mplier >> 1;
    w_cnt_dec    = r_cnt - CntOne;
  end

`ifdef MULT_EARLY_TERM_EN
  // Stop once no set multiplier bits remain; the counter still bounds the loop.
  assign w_calc_last = (w_cnt_dec == '0) || (w_mplier_shr == '0);
`else
  assign w_calc_last = (w_cnt_dec == '0);
`endif

  // FSM and datapath next-state selection
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_acc_next    = r_acc;
    w_neg_next    = r_neg;
    w_done_next   = 1'b0;
    w_hi_next     = r_hi;
    w_lo_next     = r_lo;

    case (r_state)
      StIdle: begin
        if (mult_valid) begin
          w_mcand_next  = {{WIDTH{1'b0}}, w_op1_mag};
          w_mplier_next = w_op2_mag;
          w_neg_next    = w_neg_in;
          w_acc_next    = '0;
          w_cnt_next    = CntInit;
          w_state_next  = StCalc;
        end
      end
      StCalc: begin
        w_acc_next    = w_acc_sum;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = w_mplier_shr;
        w_cnt_next    = w_cnt_dec;
        if (w_calc_last) begin
          w_state_next = StSign;
        end
      end
      StSign: begin
        // Zero negates to zero, so a zero operand needs no special case.
        if (r_neg) begin
          w_acc_next = -r_acc;
        end
        w_state_next = StDone;
      end
      StDone: begin
        // Results register on leaving DONE so HI/LO and the pulse appear together.
        w_hi_next    = r_acc[PW-1:WIDTH];
        w_lo_next    = r_acc[WIDTH-1:0];
        w_done_next  = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_acc    <= w_acc_next;
      r_neg    <= w_neg_next;
      r_done   <= w_done_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
    end
  end

  // Outputs
  always_comb begin
    mult_ready = (r_state == StIdle);
    mult_done  = r_done;
    product_hi = r_hi;
    product_lo = r_lo;
  end

endmodule

// File: tb/tb_iter_mult_unit.sv
// Directed self-checking bench for iter_mult_unit (WIDTH=32), either build of
// MULT_EARLY_TERM_EN.
module tb_iter_mult_unit;

  localparam int W = 32;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mult_valid = 1'b0;
  logic         mult_signed = 1'b0;
  logic [W-1:0] mult_op1 = '0;
  logic [W-1:0] mult_op2 = '0;
  logic         mult_ready;
  logic         mult_done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  iter_mult_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_valid (mult_valid),
    .mult_signed(mult_signed),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .mult_ready (mult_ready),
    .mult_done  (mult_done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always #5 clk = ~clk;

  // Edges from accept to the cycle with mult_done high.
  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
    logic [W-1:0] m;
    int hb;
    m  = (s && b[W-1]) ? -b : b;
    hb = 0;
    for (int i = 0; i < W; i++) if (m[i]) hb = i;
    return EarlyTerm ? hb + 3 : W + 2;
  endfunction

  function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Issue one request and wait (bounded) for its result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output bit stable, output bit busy);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!mult_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    mult_op1 = a;
    mult_op2 = b;
    mult_signed = s;
    mult_valid = 1'b1;
    @(posedge clk);
    #1;
    mult_valid = 1'b0;
    busy = !mult_ready;
    stable = (product_hi === prev_hi) && (product_lo === prev_lo);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (mult_done) begin
        lat = n;
        break;
      end
      if (product_hi !== prev_hi || product_lo !== prev_lo) stable = 1'b0;
    end
    hi = product_hi;
    lo = product_lo;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (mult_ready !== 1'b1 || mult_done !== 1'b0 || product_hi !== '0 || product_lo !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got ready=%b done=%b hi=%h lo=%h want 1 0 0 0",
               mult_ready, mult_done, product_hi, product_lo);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mult_ready !== 1'b1 || mult_done !== 1'b0 || product_hi !== '0 || product_lo !== '0) begin
      n_fail++;
      $display("FAIL reset_released: got ready=%b done=%b hi=%h lo=%h want 1 0 0 0",
               mult_ready, mult_done, product_hi, product_lo);
    end
  endtask

  task automatic test_unsigned();
    vec_t v[3];
    int lat;
    logic [W-1:0] hi, lo;
    bit st, bz;
    v[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    v[1] = '{32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780};
    v[2] = '{32'hFFFFFFFF, 32'd31,       1'b0, 32'h0000001E, 32'hFFFFFFE1};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, lat, hi, lo, st, bz);
      n_checks++;
      if (hi !== v[i].hi || lo !== v[i].lo) begin
        n_fail++;
        $display("FAIL unsigned[%0d] product: got %h_%h want %h_%h", i, hi, lo, v[i].hi, v[i].lo);
      end
      n_checks++;
      if (lat != ((i == 0 && !EarlyTerm) ? 34 : exp_lat(v[i].b, v[i].s))) begin
        n_fail++;
        $display("FAIL unsigned[%0d] latency: got %0d want %0d", i, lat, exp_lat(v[i].b, v[i].s));
      end
      n_checks++;
      if (!st || !bz) begin
        n_fail++;
        $display("FAIL unsigned[%0d] busy_hold: got stable=%0d busy=%0d want 1 1", i, st, bz);
      end
      prev_hi = v[i].hi;
      prev_lo = v[i].lo;
    end
  endtask

  task automatic test_signed();
    vec_t v[5];
    int lat;
    logic [W-1:0] hi, lo;
    bit st, bz;
    v[0] = '{32'hFFFFFFFF, 32'd31,       1'b1, 32'hFFFFFFFF, 32'hFFFFFFE1};
    v[1] = '{32'd18,       32'd31,       1'b1, 32'h00000000, 32'h0000022E};
    v[2] = '{32'hFFFFFFFD, 32'd7,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[3] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000};
    v[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, lat, hi, lo, st, bz);
      n_checks++;
      if (hi !== v[i].hi || lo !== v[i].lo) begin
        n_fail++;
        $display("FAIL signed[%0d] product: got %h_%h want %h_%h", i, hi, lo, v[i].hi, v[i].lo);
      end
      n_checks++;
      if (lat != exp_lat(v[i].b, v[i].s) || !st || !bz) begin
        n_fail++;
        $display("FAIL signed[%0d] timing: got lat=%0d stable=%0d busy=%0d want %0d 1 1",
                 i, lat, st, bz, exp_lat(v[i].b, v[i].s));
      end
      prev_hi = v[i].hi;
      prev_lo = v[i].lo;
    end
  endtask

  task automatic test_boundary();
    vec_t v[4];
    int lat;
    logic [W-1:0] hi, lo;
    bit st, bz;
    v[0] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    v[1] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    v[2] = '{32'h00000000, 32'hFFFFFFFB, 1'b1, 32'h00000000, 32'h00000000};
    v[3] = '{32'hFFFFFFFB, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, lat, hi, lo, st, bz);
      n_checks++;
      if (hi !== v[i].hi || lo !== v[i].lo) begin
        n_fail++;
        $display("FAIL boundary[%0d] product: got %h_%h want %h_%h", i, hi, lo, v[i].hi, v[i].lo);
      end
      n_checks++;
      if (lat != exp_lat(v[i].b, v[i].s) || !st || !bz) begin
        n_fail++;
        $display("FAIL boundary[%0d] timing: got lat=%0d stable=%0d busy=%0d want %0d 1 1",
                 i, lat, st, bz, exp_lat(v[i].b, v[i].s));
      end
      prev_hi = v[i].hi;
      prev_lo = v[i].lo;
    end
  endtask

  task automatic test_early_term();
    int lat;
    logic [W-1:0] hi, lo;
    bit st, bz;
    run_op(32'd5, 32'd1, 1'b0, lat, hi, lo, st, bz);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h5 || lat != (EarlyTerm ? 3 : 34)) begin
      n_fail++;
      $display("FAIL early_5x1: got %h_%h lat=%0d want 00000000_00000005 lat=%0d",
               hi, lo, lat, EarlyTerm ? 3 : 34);
    end
    prev_hi = 32'h0;
    prev_lo = 32'h5;
    run_op(32'd5, 32'h00010000, 1'b0, lat, hi, lo, st, bz);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h00050000 || lat != (EarlyTerm ? 19 : 34)) begin
      n_fail++;
      $display("FAIL early_5x10000: got %h_%h lat=%0d want 00000000_00050000 lat=%0d",
               hi, lo, lat, EarlyTerm ? 19 : 34);
    end
    prev_hi = 32'h0;
    prev_lo = 32'h00050000;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit st;
    @(negedge clk);
    mult_signed = 1'b0;
    mult_op1 = 32'd3;
    mult_op2 = 32'd4;
    mult_valid = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (mult_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy: got ready=%b want 0", mult_ready);
    end
    st = 1'b1;
    lat = -1;
    // Keep valid high with changing operands; none of these may be taken.
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      mult_op1 = $urandom;
      mult_op2 = $urandom;
      @(posedge clk);
      #1;
      if (mult_done) begin
        lat = n;
        break;
      end
      if (product_hi !== prev_hi || product_lo !== prev_lo) st = 1'b0;
    end
    mult_op1 = 32'd7;
    mult_op2 = 32'd6;
    n_checks++;
    if (product_hi !== 32'h0 || product_lo !== 32'hC || lat != exp_lat(32'd4, 1'b0) || !st) begin
      n_fail++;
      $display("FAIL b2b_first: got %h_%h lat=%0d stable=%0d want 00000000_0000000c lat=%0d 1",
               product_hi, product_lo, lat, st, exp_lat(32'd4, 1'b0));
    end
    n_checks++;
    if (mult_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_after_done: got ready=%b want 1", mult_ready);
    end
    prev_hi = 32'h0;
    prev_lo = 32'hC;
    @(posedge clk);
    #1;
    mult_valid = 1'b0;
    n_checks++;
    if (mult_ready !== 1'b0 || mult_done !== 1'b0 || product_lo !== 32'hC) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got ready=%b done=%b lo=%h want 0 0 0000000c",
               mult_ready, mult_done, product_lo);
    end
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (mult_done) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (product_hi !== 32'h0 || product_lo !== 32'd42 || lat != exp_lat(32'd6, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_second: got %h_%h lat=%0d want 00000000_0000002a lat=%0d",
               product_hi, product_lo, lat, exp_lat(32'd6, 1'b0));
    end
    prev_hi = 32'h0;
    prev_lo = 32'd42;
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] hi, lo, a, b;
    logic [2*W-1:0] exp;
    logic s;
    bit st, bz;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'h00000003 : $urandom;
      s = i[0];
      exp = golden(a, b, s);
      run_op(a, b, s, lat, hi, lo, st, bz);
      n_checks++;
      if ({hi, lo} !== exp || lat != exp_lat(b, s)) begin
        n_fail++;
        $display("FAIL random[%0d] %h*%h s=%0d: got %h_%h lat=%0d want %h lat=%0d",
                 i, a, b, s, hi, lo, lat, exp, exp_lat(b, s));
      end
      prev_hi = exp[2*W-1:W];
      prev_lo = exp[W-1:0];
    end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    int lat;
    logic [W-1:0] hi, lo;
    bit st, bz;
    @(negedge clk);
    mult_signed = 1'b1;
    mult_op1 = 32'h80000000;
    mult_op2 = 32'h80000000;
    mult_valid = 1'b1;
    @(posedge clk);
    #1;
    mult_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (mult_ready !== 1'b1 || mult_done !== 1'b0 || product_hi !== '0 || product_lo !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: got ready=%b done=%b hi=%h lo=%h want 1 0 0 0",
               mult_ready, mult_done, product_hi, product_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    saw_done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (mult_done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done || mult_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_done: got saw_done=%0d ready=%b want 0 1", saw_done, mult_ready);
    end
    run_op(32'd18, 32'd31, 1'b1, lat, hi, lo, st, bz);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0000022E || !st) begin
      n_fail++;
      $display("FAIL abort_recover: got %h_%h stable=%0d want 00000000_0000022e 1", hi, lo, st);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundary();
    test_early_term();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
